// File: rtl/mc_ctrl_unit_hs.sv
// mc_ctrl_unit_hs -- multicycle MIPS control FSM with a memory ready handshake.
//
// Steps every instruction through fetch, decode, execute, memory and write-back
// states. Memory states wait on mem_ready. An optional timeout traps a stalled
// memory into a sticky BUS_ERR state. Unknown opcodes take a one-cycle trap to
// the exception vector. Branches resolve here from the ALU zero flag.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   op, funct  in   opcode IR[31:26] and function field IR[5:0]
//   zero       in   ALU zero flag
//   mem_ready  in   memory access completes this cycle
//   pc_wr, iord, mem_rd, mem_wr, ir_wr, memto_reg, pc_src,
//   alu_op, alu_src_a, alu_src_b, reg_wr, reg_dst
//              out  datapath controls, combinational from state and inputs
//   illegal    out  one-cycle pulse on an illegal opcode
//   bus_err    out  high while parked in BUS_ERR after a memory timeout
//   state      out  current state code, for debug
module mc_ctrl_unit_hs #(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned EN_JAL      = 1,
  parameter int unsigned EN_BNE      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               iord,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               ir_wr,
  output logic [1:0]         memto_reg,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic               illegal,
  output logic               bus_err,
  output logic [4:0]         state
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEM_ADDR = 5'd2,
    S_MEM_RD   = 5'd3,
    S_MEM_WB   = 5'd4,
    S_MEM_WR   = 5'd5,
    S_R_EXEC   = 5'd6,
    S_R_WB     = 5'd7,
    S_BRANCH   = 5'd8,
    S_JUMP     = 5'd9,
    S_JAL      = 5'd10,
    S_I_EXEC   = 5'd11,
    S_I_WB     = 5'd12,
    S_ILLEGAL  = 5'd13,
    S_BUS_ERR  = 5'd14
  } state_e;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_ADDU  = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_LUI   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_RFUNC = 4'b1100;

  // Counter only needs to reach MEM_TIMEOUT-1; the trap fires on that cycle.
  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    alu_code;
  logic          waiting;
  logic          timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A timeout cycle is one where the count already covers the earlier stalled
  // cycles and this one stalls too; mem_ready in that cycle still wins.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                    (state_q == S_MEM_WR)) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    pc_wr     = 1'b0;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ir_wr     = 1'b0;
    memto_reg = 2'b00;
    pc_src    = 2'b00;
    alu_code  = ALU_ADD;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    reg_wr    = 1'b0;
    reg_dst   = 2'b00;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = (EN_BNE != 0) ? S_BRANCH : S_ILLEGAL;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = (EN_JAL != 0) ? S_JAL : S_ILLEGAL;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_LUI,
          OP_ORI, OP_SLTI, OP_SLTIU, OP_XORI:
                        state_d = S_I_EXEC;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_wr    = 1'b1;
        memto_reg = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        // sll, srl and sra take their A operand from the shamt field.
        alu_src_a = ((funct == 6'b000000) || (funct == 6'b000010) ||
                     (funct == 6'b000011)) ? 2'b10 : 2'b01;
        alu_code  = ALU_RFUNC;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_wr  = 1'b1;
        reg_dst = 2'b01;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_code  = ALU_SUB;
        pc_src    = 2'b01;
        pc_wr     = (op == OP_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_wr   = 1'b1;
        pc_src  = 2'b10;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC was already incremented in FETCH, so it is the link address.
        pc_wr     = 1'b1;
        pc_src    = 2'b10;
        reg_wr    = 1'b1;
        reg_dst   = 2'b10;
        memto_reg = 2'b10;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (op)
          OP_ADDIU: alu_code = ALU_ADDU;
          OP_ANDI:  alu_code = ALU_AND;
          OP_LUI:   alu_code = ALU_LUI;
          OP_ORI:   alu_code = ALU_OR;
          OP_SLTI:  alu_code = ALU_SLT;
          OP_SLTIU: alu_code = ALU_SLTU;
          OP_XORI:  alu_code = ALU_XOR;
          default:  alu_code = ALU_ADD;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        pc_wr   = 1'b1;
        pc_src  = 2'b11;
        state_d = S_FETCH;
      end
      S_BUS_ERR: begin
        bus_err = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_BUS_ERR;
  end

  // Count stalled cycles; any state change or a ready cycle restarts the count.
  always_comb begin
    cnt_d = '0;
    if ((MEM_TIMEOUT != 0) && waiting && (state_d == state_q))
      cnt_d = cnt_q + CW'(1);
  end

  assign alu_op = ALUOP_W'(alu_code);
  assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit_hs.sv
// tb_mc_ctrl_unit_hs -- self-checking bench for mc_ctrl_unit_hs.
//
// Two instances share all inputs: "main" uses default parameters and "alt" uses
// MEM_TIMEOUT=4 with jal disabled. Each applied cycle pushes both instances'
// expected output vectors (hand-written state sequence plus a reference output
// table) onto a queue; the falling edge pops and compares them.
module tb_mc_ctrl_unit_hs;

  typedef struct packed {
    logic [4:0] st;
    logic       pcWr;
    logic       iord;
    logic       memRd;
    logic       memWr;
    logic       irWr;
    logic [1:0] memtoReg;
    logic [1:0] pcSrc;
    logic [3:0] aluOp;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic       regWr;
    logic [1:0] regDst;
    logic       illegal;
    logic       busErr;
  } ctrlVec_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BAD = 6'h3F;

  localparam logic [4:0] FE = 5'd0,  DE = 5'd1,  MA = 5'd2,  MR = 5'd3;
  localparam logic [4:0] MB = 5'd4,  MW = 5'd5,  RE = 5'd6,  RW = 5'd7;
  localparam logic [4:0] BR = 5'd8,  JP = 5'd9,  JL = 5'd10, IE = 5'd11;
  localparam logic [4:0] IW = 5'd12, IL = 5'd13, BE = 5'd14;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic mPcWr, mIord, mMemRd, mMemWr, mIrWr, mRegWr, mIllegal, mBusErr;
  logic [1:0] mMemtoReg, mPcSrc, mSrcA, mSrcB, mRegDst;
  logic [3:0] mAluOp;
  logic [4:0] mState;
  logic aPcWr, aIord, aMemRd, aMemWr, aIrWr, aRegWr, aIllegal, aBusErr;
  logic [1:0] aMemtoReg, aPcSrc, aSrcA, aSrcB, aRegDst;
  logic [3:0] aAluOp;
  logic [4:0] aState;

  int vecCount = 0;
  int errCount = 0;
  ctrlVec_t expQ[$];

  mc_ctrl_unit_hs dutMain (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(mPcWr), .iord(mIord), .mem_rd(mMemRd),
    .mem_wr(mMemWr), .ir_wr(mIrWr), .memto_reg(mMemtoReg), .pc_src(mPcSrc),
    .alu_op(mAluOp), .alu_src_a(mSrcA), .alu_src_b(mSrcB), .reg_wr(mRegWr),
    .reg_dst(mRegDst), .illegal(mIllegal), .bus_err(mBusErr), .state(mState)
  );

  mc_ctrl_unit_hs #(.MEM_TIMEOUT(4), .EN_JAL(0)) dutAlt (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(aPcWr), .iord(aIord), .mem_rd(aMemRd),
    .mem_wr(aMemWr), .ir_wr(aIrWr), .memto_reg(aMemtoReg), .pc_src(aPcSrc),
    .alu_op(aAluOp), .alu_src_a(aSrcA), .alu_src_b(aSrcB), .reg_wr(aRegWr),
    .reg_dst(aRegDst), .illegal(aIllegal), .bus_err(aBusErr), .state(aState)
  );

  ctrlVec_t obsMain, obsAlt;
  assign obsMain = '{mState, mPcWr, mIord, mMemRd, mMemWr, mIrWr, mMemtoReg,
                     mPcSrc, mAluOp, mSrcA, mSrcB, mRegWr, mRegDst, mIllegal,
                     mBusErr};
  assign obsAlt  = '{aState, aPcWr, aIord, aMemRd, aMemWr, aIrWr, aMemtoReg,
                     aPcSrc, aAluOp, aSrcA, aSrcB, aRegWr, aRegDst, aIllegal,
                     aBusErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output table: what each state drives for the given inputs.
  function automatic ctrlVec_t refOut(input logic [4:0] st, input logic [5:0] o,
                                      input logic [5:0] f, input logic z,
                                      input logic r);
    ctrlVec_t v;
    v = '0;
    v.st = st;
    case (st)
      FE: begin
        v.memRd = 1'b1; v.srcB = 2'b01;
        if (r) begin v.irWr = 1'b1; v.pcWr = 1'b1; end
      end
      DE: v.srcB = 2'b11;
      MA: begin v.srcA = 2'b01; v.srcB = 2'b10; end
      MR: begin v.memRd = 1'b1; v.iord = 1'b1; end
      MB: begin v.regWr = 1'b1; v.memtoReg = 2'b01; end
      MW: begin v.memWr = 1'b1; v.iord = 1'b1; end
      RE: begin
        v.srcA  = (f == 6'h00 || f == 6'h02 || f == 6'h03) ? 2'b10 : 2'b01;
        v.aluOp = 4'b1100;
      end
      RW: begin v.regWr = 1'b1; v.regDst = 2'b01; end
      BR: begin
        v.srcA = 2'b01; v.aluOp = 4'b0001; v.pcSrc = 2'b01;
        v.pcWr = (o == OP_BNE) ? !z : z;
      end
      JP: begin v.pcWr = 1'b1; v.pcSrc = 2'b10; end
      JL: begin
        v.pcWr = 1'b1; v.pcSrc = 2'b10; v.regWr = 1'b1;
        v.regDst = 2'b10; v.memtoReg = 2'b10;
      end
      IE: begin
        v.srcA = 2'b01; v.srcB = 2'b10;
        case (o)
          OP_ORI:  v.aluOp = 4'b0101;
          OP_LUI:  v.aluOp = 4'b0100;
          OP_SLTI: v.aluOp = 4'b0110;
          default: v.aluOp = 4'b0000;
        endcase
      end
      IW: v.regWr = 1'b1;
      IL: begin v.illegal = 1'b1; v.pcWr = 1'b1; v.pcSrc = 2'b11; end
      BE: v.busErr = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // One cycle: drive inputs, queue both expected vectors, compare on negedge,
  // then advance to just after the next rising edge.
  task automatic applyStimulus(input string tag, input logic [5:0] o,
                               input logic [5:0] f, input logic z,
                               input logic r, input logic rn,
                               input logic [4:0] sMain, input logic [4:0] sAlt);
    ctrlVec_t eMain, eAlt;
    op = o; funct = f; zero = z; mem_ready = r; rst_n = rn;
    expQ.push_back(refOut(sMain, o, f, z, r));
    expQ.push_back(refOut(sAlt, o, f, z, r));
    @(negedge clk);
    if (expQ.size() < 2) begin
      checkOutput({tag, "/queue"}, 32'(expQ.size()), 32'd2);
    end else begin
      eMain = expQ.pop_front();
      eAlt  = expQ.pop_front();
      checkOutput({tag, "/main"}, 32'(obsMain), 32'(eMain));
      checkOutput({tag, "/alt"},  32'(obsAlt),  32'(eAlt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus("reset", OP_R, 6'h20, 0, 0, 0, FE, FE);

    // add with memory always ready
    applyStimulus("add", OP_R, 6'h20, 0, 1, 1, FE, FE);
    applyStimulus("add", OP_R, 6'h20, 0, 1, 1, DE, DE);
    applyStimulus("add", OP_R, 6'h20, 0, 1, 1, RE, RE);
    applyStimulus("add", OP_R, 6'h20, 0, 1, 1, RW, RW);

    // lw with three stall cycles in FETCH and MEM_RD; alt's timeout of 4
    // must not fire because ready arrives on the fourth cycle
    for (int i = 0; i < 3; i++) applyStimulus("lw", OP_LW, 6'h00, 0, 0, 1, FE, FE);
    applyStimulus("lw", OP_LW, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("lw", OP_LW, 6'h00, 0, 0, 1, DE, DE);
    applyStimulus("lw", OP_LW, 6'h00, 0, 0, 1, MA, MA);
    for (int i = 0; i < 3; i++) applyStimulus("lw", OP_LW, 6'h00, 0, 0, 1, MR, MR);
    applyStimulus("lw", OP_LW, 6'h00, 0, 1, 1, MR, MR);
    applyStimulus("lw", OP_LW, 6'h00, 0, 1, 1, MB, MB);

    // branches with both zero values
    for (int i = 0; i < 4; i++) begin
      logic [5:0] bop;
      logic       bz;
      bop = (i < 2) ? OP_BEQ : OP_BNE;
      bz  = (i % 2 == 0);
      applyStimulus("branch", bop, 6'h00, bz, 1, 1, FE, FE);
      applyStimulus("branch", bop, 6'h00, bz, 1, 1, DE, DE);
      applyStimulus("branch", bop, 6'h00, bz, 1, 1, BR, BR);
    end

    // sll uses shamt as ALU A
    applyStimulus("sll", OP_R, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("sll", OP_R, 6'h00, 0, 1, 1, DE, DE);
    applyStimulus("sll", OP_R, 6'h00, 0, 1, 1, RE, RE);
    applyStimulus("sll", OP_R, 6'h00, 0, 1, 1, RW, RW);

    // I-type ALU op selection
    for (int i = 0; i < 3; i++) begin
      logic [5:0] iop;
      iop = (i == 0) ? OP_ORI : (i == 1) ? OP_LUI : OP_SLTI;
      applyStimulus("itype", iop, 6'h00, 0, 1, 1, FE, FE);
      applyStimulus("itype", iop, 6'h00, 0, 1, 1, DE, DE);
      applyStimulus("itype", iop, 6'h00, 0, 1, 1, IE, IE);
      applyStimulus("itype", iop, 6'h00, 0, 1, 1, IW, IW);
    end

    // j, then jal (illegal in alt)
    applyStimulus("j", OP_J, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("j", OP_J, 6'h00, 0, 1, 1, DE, DE);
    applyStimulus("j", OP_J, 6'h00, 0, 1, 1, JP, JP);
    applyStimulus("jal", OP_JAL, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("jal", OP_JAL, 6'h00, 0, 1, 1, DE, DE);
    applyStimulus("jal", OP_JAL, 6'h00, 0, 1, 1, JL, IL);

    // sw with one stall cycle
    applyStimulus("sw", OP_SW, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("sw", OP_SW, 6'h00, 0, 1, 1, DE, DE);
    applyStimulus("sw", OP_SW, 6'h00, 0, 1, 1, MA, MA);
    applyStimulus("sw", OP_SW, 6'h00, 0, 0, 1, MW, MW);
    applyStimulus("sw", OP_SW, 6'h00, 0, 1, 1, MW, MW);

    // reset during a stalled MEM_WR aborts the store
    applyStimulus("swrst", OP_SW, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("swrst", OP_SW, 6'h00, 0, 1, 1, DE, DE);
    applyStimulus("swrst", OP_SW, 6'h00, 0, 1, 1, MA, MA);
    applyStimulus("swrst", OP_SW, 6'h00, 0, 0, 0, MW, MW);

    // illegal opcode trap
    applyStimulus("illegal", OP_BAD, 6'h00, 0, 1, 1, FE, FE);
    applyStimulus("illegal", OP_BAD, 6'h00, 0, 1, 1, DE, DE);
    applyStimulus("illegal", OP_BAD, 6'h00, 0, 1, 1, IL, IL);

    // four stalled fetches: alt times out, main keeps waiting
    for (int i = 0; i < 4; i++) applyStimulus("timeout", OP_R, 6'h20, 0, 0, 1, FE, FE);
    applyStimulus("timeout", OP_R, 6'h20, 0, 1, 1, FE, BE);
    applyStimulus("timeout", OP_R, 6'h20, 0, 1, 1, DE, BE);
    applyStimulus("timeout", OP_R, 6'h20, 0, 1, 1, RE, BE);
    applyStimulus("timeout", OP_R, 6'h20, 0, 1, 1, RW, BE);
    applyStimulus("timeout", OP_R, 6'h20, 0, 1, 0, FE, BE);
    applyStimulus("recover", OP_R, 6'h20, 0, 1, 1, FE, FE);
    applyStimulus("recover", OP_R, 6'h20, 0, 1, 1, DE, DE);
    applyStimulus("recover", OP_R, 6'h20, 0, 1, 1, RE, RE);
    applyStimulus("recover", OP_R, 6'h20, 0, 1, 1, RW, RW);
    applyStimulus("recover", OP_R, 6'h20, 0, 1, 1, FE, FE);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
